gh18b20_seq: RTL and testbench

Transaction sequencer for the gh18b20 single-sensor temperature path. It drives a bit-level 1-wire PHY (reset/presence, write-bit, read-bit slots) through a request/done handshake. It runs the full measurement cycle periodically: reset, Skip ROM, Convert T, conversion wait, reset, Skip ROM, Read Scratchpad, then 16 data bits. It delivers the raw 16-bit temperature word to the display path and flags an absent sensor after bounded retries.

---
 rtl/gh18b20_seq.sv | 237 +++++++++++++++++++++++
 tb/tb_gh18b20_seq.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gh18b20_seq.sv
// gh18b20_seq: measurement sequencer for the gh18b20 1-wire temperature sensor.
// Runs the cycle reset / Skip ROM / Convert T / wait / reset / Skip ROM /
// Read Scratchpad / 16 read slots.  It then publishes the raw temperature word
// and idles for a period.  A bit-level PHY is driven with one command at a time.
//
// Ports:
//   sys_clk, sys_rst_n  clock, asynchronous active-low reset
//   en                  level, permits a new transaction to start from IDLE
//   phy_req             1-cycle pulse, launches phy_cmd/phy_wbit
//   phy_cmd[1:0]        00 reset/presence, 01 write bit, 10 read bit
//   phy_wbit            bit to write for cmd 01
//   phy_done            1-cycle pulse, outstanding command completed
//   phy_rbit            read bit, valid with phy_done for cmd 10
//   phy_presence        presence flag, valid with phy_done for cmd 00
//   temp_data[15:0]     last good scratchpad bytes {MSB, LSB}
//   temp_valid          1-cycle pulse when temp_data updates
//   sensor_err          presence failed P_RETRY_MAX times in a row
//   busy                high outside IDLE and PERIOD
module gh18b20_seq #(
    parameter int unsigned P_CONV_WAIT = 37_500_000,
    parameter int unsigned P_PERIOD    = 50_000_000,
    parameter int unsigned P_RETRY_MAX = 3
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        en,
    output logic        phy_req,
    output logic [1:0]  phy_cmd,
    output logic        phy_wbit,
    input  logic        phy_done,
    input  logic        phy_rbit,
    input  logic        phy_presence,
    output logic [15:0] temp_data,
    output logic        temp_valid,
    output logic        sensor_err,
    output logic        busy
);

    localparam int unsigned CONV_W = (P_CONV_WAIT > 1) ? $clog2(P_CONV_WAIT) : 1;
    localparam int unsigned PER_W  = (P_PERIOD > 1) ? $clog2(P_PERIOD) : 1;
    localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'(P_CONV_WAIT - 1);
    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(P_PERIOD - 1);
    localparam logic [2:0]        RETRY_SAT = 3'(P_RETRY_MAX);

    localparam logic [1:0] CMD_RST = 2'b00;
    localparam logic [1:0] CMD_WR  = 2'b01;
    localparam logic [1:0] CMD_RD  = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST1,
        S_TX_CC1,
        S_TX_44,
        S_CONV,
        S_RST2,
        S_TX_CC2,
        S_TX_BE,
        S_RX,
        S_RETRY,
        S_PERIOD
    } state_t;

    state_t state, state_n;

    logic [3:0]        bit_cnt, bit_n;
    logic [2:0]        retry_cnt, retry_n;
    logic [CONV_W-1:0] conv_cnt, conv_n;
    logic [PER_W-1:0]  per_cnt, per_n;
    logic [15:0]       shifter, shift_n;
    logic [15:0]       tdata_n;
    logic              tvalid_n;
    logic              err_n;
    logic              outstanding, out_n;
    logic              req_n;
    logic [1:0]        cmd_n;
    logic              wbit_n;
    logic              done_v;
    logic [7:0]        tx_byte;

    function automatic logic is_phy(input state_t s);
        logic r;
        case (s)
            S_RST1, S_TX_CC1, S_TX_44, S_RST2,
            S_TX_CC2, S_TX_BE, S_RX:         r = 1'b1;
            default:                         r = 1'b0;
        endcase
        return r;
    endfunction

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            retry_cnt   <= '0;
            conv_cnt    <= '0;
            per_cnt     <= '0;
            shifter     <= '0;
            temp_data   <= '0;
            temp_valid  <= 1'b0;
            sensor_err  <= 1'b0;
            outstanding <= 1'b0;
            phy_req     <= 1'b0;
            phy_cmd     <= CMD_RST;
            phy_wbit    <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_n;
            retry_cnt   <= retry_n;
            conv_cnt    <= conv_n;
            per_cnt     <= per_n;
            shifter     <= shift_n;
            temp_data   <= tdata_n;
            temp_valid  <= tvalid_n;
            sensor_err  <= err_n;
            outstanding <= out_n;
            phy_req     <= req_n;
            phy_cmd     <= cmd_n;
            phy_wbit    <= wbit_n;
        end
    end

    always_comb begin
        state_n  = state;
        bit_n    = bit_cnt;
        retry_n  = retry_cnt;
        conv_n   = '0;
        per_n    = '0;
        shift_n  = shifter;
        tdata_n  = temp_data;
        tvalid_n = 1'b0;
        err_n    = sensor_err;
        // A done with nothing outstanding is stray and must not advance anything.
        done_v   = phy_done & outstanding;

        case (state)
            S_IDLE: begin
                if (en) state_n = S_RST1;
            end
            S_RST1, S_RST2: begin
                if (done_v) begin
                    if (phy_presence) begin
                        retry_n = '0;
                        state_n = (state == S_RST1) ? S_TX_CC1 : S_TX_CC2;
                    end else begin
                        retry_n = retry_cnt + 3'd1;
                        state_n = S_RETRY;
                    end
                end
            end
            S_TX_CC1, S_TX_44, S_TX_CC2, S_TX_BE: begin
                if (done_v) begin
                    if (bit_cnt[2:0] == 3'd7) begin
                        bit_n = '0;
                        case (state)
                            S_TX_CC1: state_n = S_TX_44;
                            S_TX_44:  state_n = S_CONV;
                            S_TX_CC2: state_n = S_TX_BE;
                            default:  state_n = S_RX;
                        endcase
                    end else begin
                        bit_n = bit_cnt + 4'd1;
                    end
                end
            end
            S_CONV: begin
                if (conv_cnt == CONV_LAST) state_n = S_RST2;
                else                       conv_n  = conv_cnt + 1'b1;
            end
            S_RX: begin
                if (done_v) begin
                    shift_n = {phy_rbit, shifter[15:1]};
                    if (bit_cnt == 4'd15) begin
                        bit_n    = '0;
                        tdata_n  = shift_n;
                        tvalid_n = 1'b1;
                        err_n    = 1'b0;
                        state_n  = S_PERIOD;
                    end else begin
                        bit_n = bit_cnt + 4'd1;
                    end
                end
            end
            S_RETRY: begin
                if (retry_cnt == RETRY_SAT) begin
                    err_n   = 1'b1;
                    retry_n = '0;
                    state_n = S_PERIOD;
                end else begin
                    state_n = S_RST1;
                end
            end
            S_PERIOD: begin
                if (per_cnt == PER_LAST) state_n = S_IDLE;
                else                     per_n   = per_cnt + 1'b1;
            end
            default: state_n = S_IDLE;
        endcase

        // Issue on a done that leaves us in a PHY state (same or next one), or
        // one cycle after entering a PHY state from a non-PHY state.
        req_n = is_phy(state_n) && (outstanding ? done_v : is_phy(state));
        out_n = req_n | (outstanding & ~done_v);

        case (state_n)
            S_TX_CC1, S_TX_CC2: tx_byte = 8'hCC;
            S_TX_44:            tx_byte = 8'h44;
            S_TX_BE:            tx_byte = 8'hBE;
            default:            tx_byte = 8'h00;
        endcase

        // Command and write bit only change at issue, so they stay stable for
        // the whole slot.
        cmd_n  = phy_cmd;
        wbit_n = phy_wbit;
        if (req_n) begin
            case (state_n)
                S_RST1, S_RST2: begin
                    cmd_n  = CMD_RST;
                    wbit_n = 1'b0;
                end
                S_RX: begin
                    cmd_n  = CMD_RD;
                    wbit_n = 1'b0;
                end
                default: begin
                    cmd_n  = CMD_WR;
                    wbit_n = tx_byte[bit_n[2:0]];
                end
            endcase
        end
    end

    always_comb begin
        busy = (state != S_IDLE) && (state != S_PERIOD);
    end

endmodule

// File: tb/tb_gh18b20_seq.sv
// Directed bench for gh18b20_seq with a behavioural 1-wire PHY model and a
// request/done monitor.  Small timing parameters keep the run short.
module tb_gh18b20_seq;

    localparam int unsigned CONV = 3;
    localparam int unsigned PER  = 2;
    localparam int unsigned RMAX = 3;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        en = 1'b0;
    logic        phy_req;
    logic [1:0]  phy_cmd;
    logic        phy_wbit;
    logic        phy_done = 1'b0;
    logic        phy_rbit = 1'b0;
    logic        phy_presence = 1'b0;
    logic [15:0] temp_data;
    logic        temp_valid;
    logic        sensor_err;
    logic        busy;

    always #5 sys_clk = ~sys_clk;

    gh18b20_seq #(
        .P_CONV_WAIT(CONV),
        .P_PERIOD   (PER),
        .P_RETRY_MAX(RMAX)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .en          (en),
        .phy_req     (phy_req),
        .phy_cmd     (phy_cmd),
        .phy_wbit    (phy_wbit),
        .phy_done    (phy_done),
        .phy_rbit    (phy_rbit),
        .phy_presence(phy_presence),
        .temp_data   (temp_data),
        .temp_valid  (temp_valid),
        .sensor_err  (sensor_err),
        .busy        (busy)
    );

    // Knobs set by the stimulus block only.
    logic [31:0] pres_pat = 32'hFFFF_FFFF;
    int          pat_epoch = 0;
    logic [15:0] rdata = 16'h0000;
    bit          rand_dly = 1'b0;

    // PHY model: one command at a time, done after 1 or 1..20 cycles.
    logic       m_act = 1'b0;
    int         m_cnt = 0;
    logic [1:0] m_cmd = 2'b00;
    int         m_rst_idx = 0;
    int         m_rx_idx = 0;
    int         m_epoch = 0;

    always @(posedge sys_clk) begin
        phy_done <= 1'b0;
        if (!sys_rst_n) begin
            m_act <= 1'b0;
        end else if (m_act) begin
            if (m_cnt <= 1) begin
                phy_done <= 1'b1;
                m_act    <= 1'b0;
                if (m_cmd == 2'b00) begin
                    phy_presence <= (m_rst_idx < 32) ? pres_pat[m_rst_idx[4:0]] : 1'b1;
                    m_rst_idx    <= m_rst_idx + 1;
                    m_rx_idx     <= 0;
                end else if (m_cmd == 2'b10) begin
                    phy_rbit <= rdata[m_rx_idx[3:0]];
                    m_rx_idx <= m_rx_idx + 1;
                end
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (phy_req) begin
            m_act <= 1'b1;
            m_cmd <= phy_cmd;
            m_cnt <= rand_dly ? int'($urandom_range(20, 1)) : 1;
        end
        if (m_epoch != pat_epoch) begin
            m_epoch   <= pat_epoch;
            m_rst_idx <= 0;
        end
    end

    // Monitor: logs every request, measures done->req gap and slot stability.
    int         cyc = 0;
    int         last_done = -10;
    int         gap1 = 0;
    int         unstable = 0;
    int         overlap = 0;
    logic       mon_out = 1'b0;
    logic [1:0] h_cmd = 2'b00;
    logic       h_wbit = 1'b0;
    logic [2:0] reqlog[$];

    always @(negedge sys_clk) begin
        cyc <= cyc + 1;
        if (!sys_rst_n) begin
            mon_out <= 1'b0;
        end else if (phy_req) begin
            if (last_done == cyc - 1) gap1 <= gap1 + 1;
            if (mon_out) overlap <= overlap + 1;
            mon_out <= 1'b1;
            h_cmd   <= phy_cmd;
            h_wbit  <= phy_wbit;
            reqlog.push_back({phy_cmd, phy_wbit});
        end else if (mon_out) begin
            if (phy_cmd !== h_cmd || phy_wbit !== h_wbit) unstable <= unstable + 1;
            if (phy_done) begin
                mon_out   <= 1'b0;
                last_done <= cyc;
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] cmd_at(input int idx);
        logic [2:0] e;
        e = (idx < reqlog.size()) ? reqlog[idx] : 3'b111;
        return e[2:1];
    endfunction

    function automatic logic [7:0] byte_at(input int idx);
        logic [7:0] b;
        logic [2:0] e;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            e = (idx + i < reqlog.size()) ? reqlog[idx + i] : 3'b111;
            b[i] = e[0];
        end
        return b;
    endfunction

    function automatic int count_cmd(input int idx, input int n, input logic [1:0] c);
        int k;
        k = 0;
        for (int i = 0; i < n; i++) if (cmd_at(idx + i) == c) k++;
        return k;
    endfunction

    task automatic start_txn();
        @(negedge sys_clk);
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            if (busy) break;
        end
        en = 1'b0;
    endtask

    task automatic wait_valid(input int budget, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge sys_clk);
            if (temp_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk(tag, found, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int g;
        int u;
        int n;
        logic found;

        // Reset state
        repeat (2) @(negedge sys_clk);
        chk("rst_req",   phy_req, 1'b0);
        chk("rst_cmd",   phy_cmd, 2'b00);
        chk("rst_wbit",  phy_wbit, 1'b0);
        chk("rst_data",  temp_data, 16'h0000);
        chk("rst_valid", temp_valid, 1'b0);
        chk("rst_err",   sensor_err, 1'b0);
        chk("rst_busy",  busy, 1'b0);
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        chk("idle_noreq", reqlog.size(), 0);

        // Nominal transaction and first-request latency
        rdata = 16'h0191;
        s = reqlog.size();
        g = gap1;
        u = unstable;
        en = 1'b1;
        @(negedge sys_clk);
        chk("lat_busy", busy, 1'b1);
        chk("lat_req0", phy_req, 1'b0);
        @(negedge sys_clk);
        chk("lat_req1", phy_req, 1'b1);
        chk("lat_cmd", phy_cmd, 2'b00);
        en = 1'b0;
        wait_valid(2000, "nom_valid");
        chk("nom_data", temp_data, 16'h0191);
        chk("nom_busy", busy, 1'b0);
        chk("nom_err", sensor_err, 1'b0);
        @(negedge sys_clk);
        chk("nom_pulse", temp_valid, 1'b0);
        chk("nom_nreq", reqlog.size() - s, 50);
        chk("nom_rst1", cmd_at(s), 2'b00);
        chk("nom_wr1", count_cmd(s + 1, 16, 2'b01), 16);
        chk("nom_cc1", byte_at(s + 1), 8'hCC);
        chk("nom_44", byte_at(s + 9), 8'h44);
        chk("nom_rst2", cmd_at(s + 17), 2'b00);
        chk("nom_wr2", count_cmd(s + 18, 16, 2'b01), 16);
        chk("nom_cc2", byte_at(s + 18), 8'hCC);
        chk("nom_be", byte_at(s + 26), 8'hBE);
        chk("nom_rd", count_cmd(s + 34, 16, 2'b10), 16);
        chk("nom_gap1", gap1 - g, 48);
        chk("nom_stable", unstable - u, 0);
        s = reqlog.size();
        repeat (10) @(negedge sys_clk);
        chk("nom_idle_req", reqlog.size() - s, 0);
        chk("nom_idle_busy", busy, 1'b0);

        // Handshake latency with random done delay, en held high
        rand_dly = 1'b1;
        rdata = 16'hA5C3;
        g = gap1;
        u = unstable;
        en = 1'b1;
        wait_valid(3000, "hs_valid");
        chk("hs_data", temp_data, 16'hA5C3);
        chk("hs_gap1", gap1 - g, 48);
        chk("hs_stable", unstable - u, 0);
        chk("hs_overlap", overlap, 0);
        // Back-to-back: PERIOD (2) + IDLE (1) + RST1 entry (1)
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            n++;
            if (phy_req) break;
        end
        chk("b2b_gap", n, 4);
        // Drop en once read slots have begun
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge sys_clk);
            if (cmd_at(reqlog.size() - 1) == 2'b10) begin
                found = 1'b1;
                break;
            end
        end
        chk("rx_reached", found, 1'b1);
        en = 1'b0;
        wait_valid(1000, "endrop_valid");
        chk("endrop_data", temp_data, 16'hA5C3);
        s = reqlog.size();
        repeat (20) @(negedge sys_clk);
        chk("endrop_req", reqlog.size() - s, 0);
        chk("endrop_busy", busy, 1'b0);
        rand_dly = 1'b0;

        // Presence failure in RST2 restarts from RST1
        pres_pat = 32'hFFFF_FFFD;
        pat_epoch = pat_epoch + 1;
        rdata = 16'h0550;
        @(negedge sys_clk);
        s = reqlog.size();
        start_txn();
        wait_valid(3000, "r2_valid");
        chk("r2_nreq", reqlog.size() - s, 68);
        chk("r2_rst2", cmd_at(s + 17), 2'b00);
        chk("r2_restart", cmd_at(s + 18), 2'b00);
        chk("r2_next", cmd_at(s + 19), 2'b01);
        chk("r2_data", temp_data, 16'h0550);
        chk("r2_err", sensor_err, 1'b0);

        // No sensor: three presence attempts, then sensor_err
        repeat (5) @(negedge sys_clk);
        pres_pat = 32'h0000_0000;
        pat_epoch = pat_epoch + 1;
        @(negedge sys_clk);
        s = reqlog.size();
        start_txn();
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge sys_clk);
            if (sensor_err) begin
                found = 1'b1;
                break;
            end
        end
        chk("ns_err", found, 1'b1);
        chk("ns_busy", busy, 1'b0);
        chk("ns_nreq", reqlog.size() - s, 3);
        chk("ns_nrst", count_cmd(s, 3, 2'b00), 3);
        repeat (10) @(negedge sys_clk);
        chk("ns_hold", sensor_err, 1'b1);
        chk("ns_quiet", reqlog.size() - s, 3);
        pres_pat = 32'hFFFF_FFFF;
        pat_epoch = pat_epoch + 1;
        rdata = 16'hFC90;
        @(negedge sys_clk);
        start_txn();
        wait_valid(2000, "rec_valid");
        chk("rec_err", sensor_err, 1'b0);
        chk("rec_data", temp_data, 16'hFC90);

        // Reset during CONV
        repeat (5) @(negedge sys_clk);
        s = reqlog.size();
        start_txn();
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge sys_clk);
            if (reqlog.size() - s >= 17 && phy_done) begin
                found = 1'b1;
                break;
            end
        end
        chk("conv_reached", found, 1'b1);
        @(posedge sys_clk);
        #2;
        chk("conv_busy", busy, 1'b1);
        chk("conv_cmd", phy_cmd, 2'b01);
        sys_rst_n = 1'b0;
        #1;
        chk("arst_req",   phy_req, 1'b0);
        chk("arst_cmd",   phy_cmd, 2'b00);
        chk("arst_wbit",  phy_wbit, 1'b0);
        chk("arst_data",  temp_data, 16'h0000);
        chk("arst_valid", temp_valid, 1'b0);
        chk("arst_err",   sensor_err, 1'b0);
        chk("arst_busy",  busy, 1'b0);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        s = reqlog.size();
        repeat (10) @(negedge sys_clk);
        chk("arst_noreq", reqlog.size() - s, 0);
        chk("arst_idle", busy, 1'b0);
        start_txn();
        wait_valid(2000, "post_valid");
        chk("post_data", temp_data, 16'hFC90);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
